// File: rtl/reaction_timer_if.sv
`timescale 1ns/1ps
// Handshake/result bundle between game control, the LFSR generator and reaction_timer.
interface reaction_timer_if;
  logic        start;
  logic        btn;
  logic [7:0]  rnd_value;
  logic        rnd_rdy;
  logic        rnd_req;
  logic        go_led;
  logic        busy;
  logic [13:0] time_ms;
  logic        result_valid;
  logic        false_start;

  modport master (
    output start, btn, rnd_value, rnd_rdy,
    input  rnd_req, go_led, busy, time_ms, result_valid, false_start
  );

  modport slave (
    input  start, btn, rnd_value, rnd_rdy,
    output rnd_req, go_led, busy, time_ms, result_valid, false_start
  );
endinterface

// File: rtl/reaction_timer.sv
`timescale 1ns/1ps
// Reaction-time game round: fetch a fresh random value, wait a random pre-delay,
// light GO and measure the player's reaction in ms, with false-start and timeout detection.
module reaction_timer #(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_SHIFT  = 3,
  parameter int MAX_TIME_MS  = 9999
) (
  input  logic           clk,
  input  logic           rst,
  reaction_timer_if.slave bus
);
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + (255 << DELAY_SHIFT) + 1);
  localparam int TW = 14;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [TW-1:0] TIME_MAX   = TW'(MAX_TIME_MS);
  localparam logic [TW-1:0] TIME_LAST  = TW'(MAX_TIME_MS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ_RND, WAIT_DELAY, GO, RESULT, FALSE_START
  } state_t;

  state_t        state_reg, state_next;
  logic          btn_reg, rdy_reg, req_reg;
  logic [PW-1:0] presc_reg;
  logic [DW-1:0] delay_reg;
  logic [TW-1:0] react_reg, time_reg;
  logic          tick, btn_rise, accept, entering_timed;
  logic          rnd_req, go_led, busy, result_valid, false_start;

  assign tick     = (presc_reg == PRESC_LAST);
  assign btn_rise = bus.btn & ~btn_reg;
  // Only a fresh rdy edge seen after the request has been up for a full cycle counts.
  assign accept   = (state_reg == REQ_RND) && req_reg && bus.rnd_rdy && !rdy_reg;
  assign entering_timed = (state_next != state_reg) &&
                          ((state_next == WAIT_DELAY) || (state_next == GO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RESULT, FALSE_START: if (bus.start) state_next = REQ_RND;
      REQ_RND:    if (accept) state_next = WAIT_DELAY;
      WAIT_DELAY: begin
        if (btn_rise)                          state_next = FALSE_START;
        else if (tick && (delay_reg <= DW'(1))) state_next = GO;
      end
      GO: if (btn_rise || (tick && (react_reg >= TIME_LAST))) state_next = RESULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rnd_req      = 1'b0;
    go_led       = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    false_start  = 1'b0;
    case (state_reg)
      REQ_RND:     begin rnd_req = 1'b1; busy = 1'b1; end
      WAIT_DELAY:  busy = 1'b1;
      GO:          begin go_led = 1'b1; busy = 1'b1; end
      RESULT:      result_valid = 1'b1;
      FALSE_START: false_start = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_reg   <= 1'b0;
      rdy_reg   <= 1'b0;
      req_reg   <= 1'b0;
      presc_reg <= '0;
      delay_reg <= '0;
      react_reg <= '0;
      time_reg  <= '0;
    end else begin
      btn_reg <= bus.btn;
      rdy_reg <= bus.rnd_rdy;
      req_reg <= rnd_req;

      if (entering_timed || tick) presc_reg <= '0;
      else                        presc_reg <= presc_reg + PW'(1);

      if (accept)
        delay_reg <= DW'(MIN_DELAY_MS) + (DW'(bus.rnd_value) << DELAY_SHIFT);
      else if ((state_reg == WAIT_DELAY) && tick && (delay_reg != '0))
        delay_reg <= delay_reg - DW'(1);

      if (state_reg != GO)                     react_reg <= '0;
      else if (tick && (react_reg < TIME_MAX)) react_reg <= react_reg + TW'(1);

      // Result is captured from the pre-increment counter, so a press on a tick reports the completed ms.
      if ((state_reg != REQ_RND) && (state_next == REQ_RND))
        time_reg <= '0;
      else if ((state_reg == WAIT_DELAY) && (state_next == FALSE_START))
        time_reg <= '0;
      else if ((state_reg == GO) && (state_next == RESULT))
        time_reg <= btn_rise ? react_reg : TIME_MAX;
    end
  end

  assign bus.rnd_req      = rnd_req;
  assign bus.go_led       = go_led;
  assign bus.busy         = busy;
  assign bus.time_ms      = time_reg;
  assign bus.result_valid = result_valid;
  assign bus.false_start  = false_start;
endmodule
